// File: rtl/video_term.sv
// video_term: 40x25 character-terminal front end driving the video character RAM, clear and vscroll inputs
// Ports: cpu_clk, reset (sync, active-high); char_valid/char_data/char_ready byte-stream input;
//   video_ce/video_we/video_addr/video_data RAM write port; video_clear, video_vscroll video control;
//   cursor_col/cursor_row cursor position; busy high whenever not idle.
// Build option: define VIDEO_TERM_TAB_EN to make 0x09 advance the cursor to the next multiple of 8.
module video_term #(
  parameter int COLS = 40,
  parameter int ROWS = 25,
  parameter int SCREEN_SIZE = 1000,
  parameter logic [7:0] FILL_CHAR = 8'h20,
  parameter int SCROLL_HOLD = 8,
  parameter int CLEAR_WAIT = 1002
) (
  input  logic       cpu_clk,
  input  logic       reset,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  output logic       video_ce,
  output logic       video_we,
  output logic [9:0] video_addr,
  output logic [7:0] video_data,
  output logic       video_clear,
  output logic       video_vscroll,
  output logic [5:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, WRITE, NEWLINE, SCROLL, CLEAR_LINE, CLEAR_ALL} state_t;
  state_t state, state_nx;
  logic [5:0] col;
  logic [4:0] row;
  logic [9:0] base, cnt, phys, clr_addr, base_nx;
  logic [7:0] byte_q;
  logic started, accept, printable;
  logic [10:0] phys_raw, clr_raw;
  assign accept = char_valid & char_ready;
  assign printable = char_data >= 8'h20 && char_data <= 8'h7e;
  assign phys_raw = 11'(base) + 11'(row) * 11'(COLS) + 11'(col);
  assign phys = phys_raw >= 11'(SCREEN_SIZE) ? 10'(phys_raw - 11'(SCREEN_SIZE)) : 10'(phys_raw);
  // The new bottom line sits one screen minus one row past the (already advanced) base.
  assign clr_raw = 11'(base) + 11'(SCREEN_SIZE - COLS) + 11'(cnt);
  assign clr_addr = clr_raw >= 11'(SCREEN_SIZE) ? 10'(clr_raw - 11'(SCREEN_SIZE)) : 10'(clr_raw);
  assign base_nx = (base + 10'(COLS) == 10'(SCREEN_SIZE)) ? '0 : base + 10'(COLS);
`ifdef VIDEO_TERM_TAB_EN
  logic [5:0] tab_raw, tab_col;
  assign tab_raw = {col[5:3] + 3'd1, 3'b000};
  assign tab_col = tab_raw > 6'(COLS - 1) ? 6'(COLS - 1) : tab_raw;
`endif
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
      base <= '0;
      cnt <= '0;
      byte_q <= '0;
      started <= 1'b0;
    end else begin
      state <= state_nx;
      started <= 1'b1;
      cnt <= state_nx != state ? '0 : cnt + 10'd1;
      case (state)
        IDLE: if (accept) begin
          byte_q <= char_data;
          if (char_data == 8'h0d) col <= '0;
          if (char_data == 8'h08 && col != '0) col <= col - 6'd1;
`ifdef VIDEO_TERM_TAB_EN
          if (char_data == 8'h09) col <= tab_col;
`endif
          if (char_data == 8'h0c) begin
            col <= '0;
            row <= '0;
            base <= '0;
          end
        end
        WRITE: col <= col == 6'(COLS - 1) ? '0 : col + 6'd1;
        NEWLINE: if (row == 5'(ROWS - 1)) base <= base_nx; else row <= row + 5'd1;
        default: ;
      endcase
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = printable ? WRITE : char_data == 8'h0a ? NEWLINE : char_data == 8'h0c ? CLEAR_ALL : IDLE;
      WRITE: state_nx = col == 6'(COLS - 1) ? NEWLINE : IDLE;
      NEWLINE: state_nx = row == 5'(ROWS - 1) ? SCROLL : IDLE;
      SCROLL: state_nx = cnt == 10'(SCROLL_HOLD - 1) ? CLEAR_LINE : SCROLL;
      CLEAR_LINE: state_nx = cnt == 10'(COLS - 1) ? IDLE : CLEAR_LINE;
      CLEAR_ALL: state_nx = cnt == 10'(CLEAR_WAIT - 1) ? IDLE : CLEAR_ALL;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    char_ready = started && state == IDLE;
    video_ce = state == WRITE || state == CLEAR_LINE;
    video_we = state == WRITE || state == CLEAR_LINE;
    video_addr = state == WRITE ? phys : state == CLEAR_LINE ? clr_addr : '0;
    video_data = state == WRITE ? byte_q : state == CLEAR_LINE ? FILL_CHAR : '0;
    video_clear = state == CLEAR_ALL && cnt == '0;
    video_vscroll = state == SCROLL;
    cursor_col = col;
    cursor_row = row;
    busy = state != IDLE;
  end
endmodule
